// File: rtl/uart_fifo_txrx.sv
// uart_fifo_txrx: byte FIFO draining into an 8N1 serial transmitter, plus an
// independent 8N1 receiver with a one-cycle valid strobe. Baud = clk / CLKS_PER_BIT.
module uart_fifo_txrx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       wr_en_i,
  input  logic [7:0] wr_data_i,
  output logic       full_o,
  output logic       empty_o,
  output logic       tx_ready_o,
  output logic       uart_tx_o,
  input  logic       uart_rx_i,
  output logic       rx_valid_o,
  output logic [7:0] rx_data_o
);
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int CNTW = AW + 1;
  localparam int CW   = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0]   BIT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0]   BIT_HALF = CW'(CLKS_PER_BIT / 2);
  localparam logic [CNTW-1:0] CNT_FULL = CNTW'(FIFO_DEPTH);

  typedef enum logic {TX_IDLE, TX_SEND} tx_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_CLEANUP} rx_state_t;

  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CNTW-1:0] count_q, count_d;
  logic            full_q, empty_q, tx_send_q;
  logic [7:0]      rd_data_q;
  logic            wr_acc, fifo_rd;

  tx_state_t       tx_state_q;
  logic [8:0]      tx_shift_q;
  logic [3:0]      tx_bit_q;
  logic [CW-1:0]   tx_cnt_q;
  logic            tx_line_q, tx_ready_q;

  rx_state_t       rx_state_q;
  logic            rx_meta_q, rx_sync_q;
  logic [CW-1:0]   rx_cnt_q;
  logic [2:0]      rx_bit_q;
  logic [7:0]      rx_shift_q, rx_data_q;
  logic            rx_valid_q;

  // FIFO handshake and next occupancy; tx_send_q blocks a second read until the FSM latches.
  always_comb begin
    wr_acc  = wr_en_i & ~full_q;
    fifo_rd = tx_ready_q & ~empty_q & ~tx_send_q;
    if (wr_acc && !fifo_rd) begin
      count_d = count_q + CNTW'(1);
    end else if (!wr_acc && fifo_rd) begin
      count_d = count_q - CNTW'(1);
    end else begin
      count_d = count_q;
    end
  end

  // Storage array, flushed logically by the pointer reset.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

  // Pointers, count, flags and the registered read port.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      full_q    <= 1'b0;
      empty_q   <= 1'b1;
      rd_data_q <= 8'h00;
      tx_send_q <= 1'b0;
    end else begin
      count_q   <= count_d;
      full_q    <= (count_d == CNT_FULL);
      empty_q   <= (count_d == CNTW'(0));
      tx_send_q <= fifo_rd;
      if (wr_acc) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (fifo_rd) begin
        rd_data_q <= mem_q[rd_ptr_q];
        rd_ptr_q  <= rd_ptr_q + AW'(1);
      end
    end
  end

  // TX FSM: start bit goes out on the latch edge; shift register holds {stop, data}.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      tx_state_q <= TX_IDLE;
      tx_shift_q <= '0;
      tx_bit_q   <= 4'd0;
      tx_cnt_q   <= '0;
      tx_line_q  <= 1'b1;
      tx_ready_q <= 1'b1;
    end else begin
      case (tx_state_q)
        TX_IDLE: begin
          if (tx_send_q) begin
            tx_shift_q <= {1'b1, rd_data_q};
            tx_line_q  <= 1'b0;
            tx_bit_q   <= 4'd0;
            tx_cnt_q   <= '0;
            tx_ready_q <= 1'b0;
            tx_state_q <= TX_SEND;
          end
        end
        TX_SEND: begin
          if (tx_cnt_q == BIT_LAST) begin
            tx_cnt_q <= '0;
            if (tx_bit_q == 4'd9) begin
              tx_line_q  <= 1'b1;
              tx_ready_q <= 1'b1;
              tx_state_q <= TX_IDLE;
            end else begin
              tx_line_q  <= tx_shift_q[0];
              tx_shift_q <= {1'b1, tx_shift_q[8:1]};
              tx_bit_q   <= tx_bit_q + 4'd1;
            end
          end else begin
            tx_cnt_q <= tx_cnt_q + CW'(1);
          end
        end
        default: begin
          tx_line_q  <= 1'b1;
          tx_ready_q <= 1'b1;
          tx_state_q <= TX_IDLE;
        end
      endcase
    end
  end

  // RX synchronizer and FSM; samples at bit centres, stop bit value is ignored.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= 3'd0;
      rx_shift_q <= 8'h00;
      rx_data_q  <= 8'h00;
      rx_valid_q <= 1'b0;
    end else begin
      rx_meta_q  <= uart_rx_i;
      rx_sync_q  <= rx_meta_q;
      rx_valid_q <= 1'b0;
      case (rx_state_q)
        RX_IDLE: begin
          rx_cnt_q <= '0;
          rx_bit_q <= 3'd0;
          if (!rx_sync_q) begin
            rx_state_q <= RX_START;
          end
        end
        RX_START: begin
          if (rx_cnt_q == BIT_HALF) begin
            rx_cnt_q   <= '0;
            rx_state_q <= rx_sync_q ? RX_IDLE : RX_DATA;
          end else begin
            rx_cnt_q <= rx_cnt_q + CW'(1);
          end
        end
        RX_DATA: begin
          if (rx_cnt_q == BIT_LAST) begin
            rx_cnt_q             <= '0;
            rx_shift_q[rx_bit_q] <= rx_sync_q;
            if (rx_bit_q == 3'd7) begin
              rx_state_q <= RX_STOP;
            end else begin
              rx_bit_q <= rx_bit_q + 3'd1;
            end
          end else begin
            rx_cnt_q <= rx_cnt_q + CW'(1);
          end
        end
        RX_STOP: begin
          if (rx_cnt_q == BIT_LAST) begin
            rx_cnt_q   <= '0;
            rx_data_q  <= rx_shift_q;
            rx_valid_q <= 1'b1;
            rx_state_q <= RX_CLEANUP;
          end else begin
            rx_cnt_q <= rx_cnt_q + CW'(1);
          end
        end
        RX_CLEANUP: rx_state_q <= RX_IDLE;
        default:    rx_state_q <= RX_IDLE;
      endcase
    end
  end

  assign full_o     = full_q;
  assign empty_o    = empty_q;
  assign tx_ready_o = tx_ready_q;
  assign uart_tx_o  = tx_line_q;
  assign rx_valid_o = rx_valid_q;
  assign rx_data_o  = rx_data_q;

endmodule

// File: tb/tb_uart_fifo_txrx.sv
// Self-checking bench for uart_fifo_txrx at 8 clocks/bit: vector tables for FIFO
// flags and RX frames, a serial-line decoder feeding a TX byte scoreboard.
module tb_uart_fifo_txrx;
  localparam int CPB   = 8;
  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       wr_en_i = 1'b0;
  logic [7:0] wr_data_i = 8'h00;
  logic       uart_rx_i = 1'b1;
  logic       full_o, empty_o, tx_ready_o, uart_tx_o, rx_valid_o;
  logic [7:0] rx_data_o;

  uart_fifo_txrx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n), .wr_en_i(wr_en_i), .wr_data_i(wr_data_i),
    .full_o(full_o), .empty_o(empty_o), .tx_ready_o(tx_ready_o), .uart_tx_o(uart_tx_o),
    .uart_rx_i(uart_rx_i), .rx_valid_o(rx_valid_o), .rx_data_o(rx_data_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic       accept;
    logic       exp_full;
    logic       exp_empty;
  } wr_vec_t;

  typedef struct {
    logic       glitch;
    logic [7:0] data;
    logic       stop;
    int         exp_cnt;
    logic [7:0] exp_data;
  } rx_vec_t;

  wr_vec_t    wr_tab[18];
  rx_vec_t    rx_tab[6];
  logic [7:0] tx_exp[$];
  logic [8:0] tx_seen[$];
  logic [7:0] rx_got[$];
  int         rx_got_cyc[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int t_w, start_c, rdy_c, bad, idx;
  logic [9:0] frame;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Serial line decoder: samples the centre of every bit, pushes {stop, data}.
  logic       mon_en = 1'b1;
  logic       mon_busy = 1'b0;
  int         mon_cnt = 0;
  logic [7:0] mon_byte = 8'h00;
  always @(negedge clk) begin
    if (!mon_en) begin
      mon_busy <= 1'b0;
      mon_cnt  <= 0;
    end else if (!mon_busy) begin
      if (uart_tx_o === 1'b0) begin
        mon_busy <= 1'b1;
        mon_cnt  <= 1;
      end
    end else begin
      mon_cnt <= mon_cnt + 1;
      if (mon_cnt >= 12 && mon_cnt <= 68 && (mon_cnt % CPB) == 4)
        mon_byte[(mon_cnt - 12) / CPB] <= uart_tx_o;
      if (mon_cnt == 76) begin
        tx_seen.push_back({uart_tx_o, mon_byte});
        mon_busy <= 1'b0;
      end
    end
  end

  // Receive strobe logger.
  always @(negedge clk) begin
    if (rx_valid_o === 1'b1) begin
      rx_got.push_back(rx_data_o);
      rx_got_cyc.push_back(cyc);
    end
  end

  task automatic check_tx_bytes(input int budget);
    int waited;
    logic [8:0] got;
    logic [7:0] exp;
    waited = 0;
    while (tx_exp.size() > 0 && waited < budget) begin
      @(negedge clk);
      waited++;
      while (tx_seen.size() > 0 && tx_exp.size() > 0) begin
        got = tx_seen.pop_front();
        exp = tx_exp.pop_front();
        check("tx_byte", 32'(got[7:0]), 32'(exp));
        check("tx_stop_bit", 32'(got[8]), 32'd1);
      end
    end
    check("tx_pending_timeout", 32'(tx_exp.size()), 32'd0);
    repeat (100) @(negedge clk);
    check("tx_extra_bytes", 32'(tx_seen.size()), 32'd0);
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop, output int fall);
    logic [9:0] fr;
    fr = {stop, b, 1'b0};
    fall = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      uart_rx_i = fr[i];
      if (i == 0) fall = cyc;
      repeat (CPB - 1) @(posedge clk);
    end
    @(posedge clk); #1;
    uart_rx_i = 1'b1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // One byte leaves for the transmitter immediately, so DEPTH+1 writes fit.
    for (int i = 0; i < 18; i++) begin
      wr_tab[i].data      = 8'(i);
      wr_tab[i].accept    = (i <= DEPTH);
      wr_tab[i].exp_full  = (i >= DEPTH);
      wr_tab[i].exp_empty = 1'b0;
    end
    rx_tab[0] = '{1'b0, 8'hA3, 1'b1, 1, 8'hA3};
    rx_tab[1] = '{1'b1, 8'h00, 1'b1, 0, 8'hA3};
    rx_tab[2] = '{1'b0, 8'h3C, 1'b1, 1, 8'h3C};
    rx_tab[3] = '{1'b0, 8'h00, 1'b1, 1, 8'h00};
    rx_tab[4] = '{1'b0, 8'hFF, 1'b1, 1, 8'hFF};
    rx_tab[5] = '{1'b0, 8'h5A, 1'b0, 1, 8'h5A};

    // Reset with random inputs
    repeat (3) begin
      @(posedge clk); #1;
      wr_en_i   = 1'($urandom_range(0, 1));
      wr_data_i = 8'($urandom);
      uart_rx_i = 1'($urandom_range(0, 1));
    end
    @(negedge clk);
    check("rst_empty", 32'(empty_o), 32'd1);
    check("rst_full", 32'(full_o), 32'd0);
    check("rst_tx_ready", 32'(tx_ready_o), 32'd1);
    check("rst_uart_tx", 32'(uart_tx_o), 32'd1);
    check("rst_rx_valid", 32'(rx_valid_o), 32'd0);
    check("rst_rx_data", 32'(rx_data_o), 32'd0);
    @(posedge clk); #1;
    wr_en_i   = 1'b0;
    uart_rx_i = 1'b1;
    @(posedge clk); #1;
    reset_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;

    // Single TX byte 0x55
    wr_en_i   = 1'b1;
    wr_data_i = 8'h55;
    tx_exp.push_back(8'h55);
    t_w = cyc;
    @(posedge clk); #1;
    wr_en_i = 1'b0;
    check("empty_after_write", 32'(empty_o), 32'd0);
    frame   = {1'b1, 8'h55, 1'b0};
    start_c = -1;
    rdy_c   = -1;
    bad     = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (start_c < 0 && uart_tx_o === 1'b0) start_c = cyc;
      if (start_c >= 0) begin
        idx = cyc - start_c;
        if (idx < 10 * CPB && uart_tx_o !== frame[idx / CPB]) bad++;
        if (rdy_c < 0 && idx > 0 && tx_ready_o === 1'b1) rdy_c = cyc;
      end
    end
    check("tx_write_to_start", 32'(start_c - t_w), 32'd3);
    check("tx_line_pattern_errs", 32'(bad), 32'd0);
    check("tx_ready_return", 32'(rdy_c - start_c), 32'(10 * CPB));
    check_tx_bytes(300);
    check("empty_after_tx", 32'(empty_o), 32'd1);

    // FIFO overflow and RX frames run concurrently (full duplex)
    fork
      begin : fifo_full
        for (int i = 0; i <= 18; i++) begin
          @(posedge clk); #1;
          if (i > 0) begin
            check($sformatf("full_flag[%0d]", i - 1), 32'(full_o), 32'(wr_tab[i-1].exp_full));
            check($sformatf("empty_flag[%0d]", i - 1), 32'(empty_o), 32'(wr_tab[i-1].exp_empty));
          end
          if (i < 18) begin
            wr_en_i   = 1'b1;
            wr_data_i = wr_tab[i].data;
            if (wr_tab[i].accept) tx_exp.push_back(wr_tab[i].data);
          end else begin
            wr_en_i = 1'b0;
          end
        end
        check_tx_bytes(3000);
        check("empty_after_drain", 32'(empty_o), 32'd1);
        check("full_after_drain", 32'(full_o), 32'd0);
      end
      begin : rx_table
        int fall_c;
        int lat;
        for (int i = 0; i < 6; i++) begin
          rx_got.delete();
          rx_got_cyc.delete();
          fall_c = 0;
          if (rx_tab[i].glitch) begin
            @(posedge clk); #1;
            uart_rx_i = 1'b0;
            repeat (2) @(posedge clk);
            #1;
            uart_rx_i = 1'b1;
          end else begin
            send_rx(rx_tab[i].data, rx_tab[i].stop, fall_c);
          end
          repeat (30) @(posedge clk);
          check($sformatf("rx_pulses[%0d]", i), 32'(rx_got.size()), 32'(rx_tab[i].exp_cnt));
          if (rx_got.size() > 0) begin
            check($sformatf("rx_data[%0d]", i), 32'(rx_got[0]), 32'(rx_tab[i].exp_data));
            lat = rx_got_cyc[0] - fall_c;
            check($sformatf("rx_latency_ok[%0d] lat=%0d", i, lat), 32'(lat >= 78 && lat <= 80), 32'd1);
          end
          check($sformatf("rx_hold[%0d]", i), 32'(rx_data_o), 32'(rx_tab[i].exp_data));
        end
      end
    join

    // Reset during data bit 4 of 0xC6 with 0x39 still queued
    @(posedge clk); #1;
    wr_en_i   = 1'b1;
    wr_data_i = 8'hC6;
    @(posedge clk); #1;
    wr_data_i = 8'h39;
    @(posedge clk); #1;
    wr_en_i = 1'b0;
    mon_en  = 1'b0;
    start_c = -1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (start_c < 0 && uart_tx_o === 1'b0) start_c = cyc;
    end
    check("abort_start_seen", 32'(start_c >= 0), 32'd1);
    while (cyc < start_c + 5 * CPB + 2) @(negedge clk);
    check("abort_bit4_low", 32'(uart_tx_o), 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b0;
    @(posedge clk); #1;
    check("abort_line_high", 32'(uart_tx_o), 32'd1);
    check("abort_empty", 32'(empty_o), 32'd1);
    check("abort_tx_ready", 32'(tx_ready_o), 32'd1);
    check("abort_rx_data_cleared", 32'(rx_data_o), 32'd0);
    reset_n = 1'b1;
    tx_seen.delete();
    tx_exp.delete();
    mon_en = 1'b1;
    bad = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (uart_tx_o !== 1'b1) bad++;
    end
    check("abort_line_idle_errs", 32'(bad), 32'd0);
    check("abort_no_residual", 32'(tx_seen.size()), 32'd0);
    check("abort_still_empty", 32'(empty_o), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
